// File: rtl/uart_receiver_if.sv
// Consumer-side handshake of the UART receiver: one received byte offered
// with valid/ready. The receiver drives the master modport.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (8N1) with a one-entry valid/ready output register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic          physical_clock,
  input  logic          reset_n,
  input  logic [31:0]   baud_divisor,
  input  logic          rx,
  uart_receiver_if.master rx_if,
  output logic          frame_error,
  output logic          overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic          parity_error
`endif
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [31:0]          div_cnt_q, div_cnt_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_error_q, parity_error_d;
  logic                 parity_ok;
`endif

  logic                 rxs;
  logic [31:0]          div_term;
  logic                 tick;
  logic                 stop_ok;

  assign rxs = sync2_q;

  // Divisor 0 behaves as 1; ">=" lets a shrunken divisor wrap at once instead of running away.
  assign div_term = (baud_divisor == 32'd0) ? 32'd0 : baud_divisor - 32'd1;
  assign tick     = (div_cnt_q >= div_term);

`ifdef UART_RX_PARITY_EN
  assign parity_ok = ~(^shift_q ^ parity_bit_q);
  assign stop_ok   = rxs & parity_ok;
`else
  assign stop_ok   = rxs;
`endif

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 32'd1;
    if (state_q == IDLE || tick) begin
      div_cnt_d = 32'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    scnt_d        = scnt_q;
    bcnt_d        = bcnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_if.rx_ready;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d   = parity_bit_q;
    parity_error_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          scnt_d  = '0;
          bcnt_d  = '0;
        end
      end

      START: begin
        if (tick) begin
          if (scnt_q == SCNT_HALF) begin
            scnt_d  = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d       = '0;
            parity_bit_d = rxs;
            state_d      = STOP;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
`endif

      // Decide mid stop bit so a frame starting right after the stop bit is not missed.
      STOP: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d        = '0;
            state_d       = IDLE;
            frame_error_d = ~rxs;
`ifdef UART_RX_PARITY_EN
            parity_error_d = ~parity_ok;
`endif
            if (stop_ok) begin
              if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge physical_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      div_cnt_q     <= 32'd0;
      state_q       <= IDLE;
      scnt_q        <= '0;
      bcnt_q        <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q   <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      div_cnt_q     <= div_cnt_d;
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      bcnt_q        <= bcnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q   <= parity_bit_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign frame_error    = frame_error_q;
  assign overrun        = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error   = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written
// glitch, overrun, reset and parity sequences, with a queue of expected bytes.
module tb_uart_receiver;

  logic        clk;
  logic        reset_n;
  logic [31:0] baud_divisor;
  logic        rx;
  logic        frame_error;
  logic        overrun;
`ifdef UART_RX_PARITY_EN
  logic        parity_error;
`endif

  uart_receiver_if #(.DATA_BITS(8)) rx_if ();

  uart_receiver #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .physical_clock(clk),
    .reset_n       (reset_n),
    .baud_divisor  (baud_divisor),
    .rx            (rx),
    .rx_if         (rx_if),
    .frame_error   (frame_error),
    .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] div;
    logic        ok;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         bit_cycles = 32;
  int         fe_cnt  = 0;
  int         ovr_cnt = 0;
  int         pe_cnt  = 0;

  // Count every high cycle, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_error === 1'b1) pe_cnt++;
`endif
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_divisor(input logic [31:0] div);
    baud_divisor = div;
    bit_cycles   = 16 * ((div == 32'd0) ? 1 : int'(div));
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop, input logic with_par, input logic par);
    rx = 1'b0;
    wait_cycles(bit_cycles);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(bit_cycles);
    end
    if (with_par) begin
      rx = par;
      wait_cycles(bit_cycles);
    end
    rx = stop;
    wait_cycles(bit_cycles);
    rx = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_bits(d, stop, 1'b1, ^d);
`else
    send_bits(d, stop, 1'b0, 1'b0);
`endif
  endtask

  // Compare the held byte against the scoreboard, then accept it for one cycle.
  task automatic consume(input string name);
    logic [7:0] exp_byte;
    check_output({name, "_valid"}, {31'd0, rx_if.rx_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check_output({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_byte = exp_q.pop_front();
      check_output({name, "_data"}, {24'd0, rx_if.rx_data}, {24'd0, exp_byte});
    end
    rx_if.rx_ready = 1'b1;
    wait_cycles(1);
    rx_if.rx_ready = 1'b0;
    check_output({name, "_valid_fall"}, {31'd0, rx_if.rx_valid}, 32'd0);
  endtask

  initial begin
    int fe0;
    int ovr0;
    int pe0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, div: 32'd2, ok: 1'b1};
    vecs[1] = '{data: 8'h55, stop: 1'b0, div: 32'd2, ok: 1'b0};
    vecs[2] = '{data: 8'h0F, stop: 1'b1, div: 32'd2, ok: 1'b1};
    vecs[3] = '{data: 8'h3C, stop: 1'b1, div: 32'd0, ok: 1'b1};
    vecs[4] = '{data: 8'h00, stop: 1'b1, div: 32'd1, ok: 1'b1};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, div: 32'd3, ok: 1'b1};
    vecs[6] = '{data: 8'h80, stop: 1'b0, div: 32'd1, ok: 1'b0};

    reset_n        = 1'b0;
    rx             = 1'b1;
    rx_if.rx_ready = 1'b0;
    set_divisor(32'd2);
    wait_cycles(4);
    check_output("reset_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_output("reset_data", {24'd0, rx_if.rx_data}, 32'd0);
    check_output("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check_output("reset_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    wait_cycles(10);

    for (int v = 0; v < 7; v++) begin
      set_divisor(vecs[v].div);
      fe0  = fe_cnt;
      ovr0 = ovr_cnt;
      if (vecs[v].ok) exp_q.push_back(vecs[v].data);
      apply_stimulus(vecs[v].data, vecs[v].stop);
      wait_cycles(2);
      check_output($sformatf("vec%0d_frame_error", v), fe_cnt - fe0, vecs[v].ok ? 0 : 1);
      check_output($sformatf("vec%0d_overrun", v), ovr_cnt - ovr0, 0);
      if (vecs[v].ok) begin
        wait_cycles(5);
        check_output($sformatf("vec%0d_valid_held", v), {31'd0, rx_if.rx_valid}, 32'd1);
        consume($sformatf("vec%0d", v));
      end else begin
        check_output($sformatf("vec%0d_valid_low", v), {31'd0, rx_if.rx_valid}, 32'd0);
      end
      wait_cycles(4 * bit_cycles);
    end

    set_divisor(32'd2);
    fe0 = fe_cnt;
    rx  = 1'b0;
    wait_cycles(6);
    rx  = 1'b1;
    wait_cycles(100);
    check_output("glitch_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_output("glitch_frame_error", fe_cnt - fe0, 0);
    exp_q.push_back(8'h3C);
    apply_stimulus(8'h3C, 1'b1);
    wait_cycles(2);
    consume("after_glitch");
    wait_cycles(20);

    fe0  = fe_cnt;
    ovr0 = ovr_cnt;
    exp_q.push_back(8'h11);
    apply_stimulus(8'h11, 1'b1);
    apply_stimulus(8'h22, 1'b1);
    wait_cycles(2);
    check_output("overrun_pulses", ovr_cnt - ovr0, 1);
    check_output("overrun_frame_error", fe_cnt - fe0, 0);
    consume("overrun_keep");
    wait_cycles(20);

    apply_stimulus(8'h5A, 1'b1);
    wait_cycles(2);
    check_output("pre_reset_valid", {31'd0, rx_if.rx_valid}, 32'd1);
    check_output("pre_reset_data", {24'd0, rx_if.rx_data}, 32'h5A);
    rx = 1'b0;
    wait_cycles(bit_cycles);
    rx = 1'b1;
    wait_cycles(3 * bit_cycles + bit_cycles / 2);
    reset_n = 1'b0;
    #1;
    check_output("midreset_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    check_output("midreset_data", {24'd0, rx_if.rx_data}, 32'd0);
    check_output("midreset_frame_error", {31'd0, frame_error}, 32'd0);
    check_output("midreset_overrun", {31'd0, overrun}, 32'd0);
    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(20);
    exp_q.push_back(8'h81);
    apply_stimulus(8'h81, 1'b1);
    wait_cycles(2);
    consume("after_reset");
    wait_cycles(20);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_bits(8'h07, 1'b1, 1'b1, 1'b1);
    wait_cycles(2);
    check_output("parity_good_error", pe_cnt - pe0, 0);
    consume("parity_good");
    wait_cycles(20);
    pe0 = pe_cnt;
    fe0 = fe_cnt;
    send_bits(8'h07, 1'b1, 1'b1, 1'b0);
    wait_cycles(2);
    check_output("parity_bad_error", pe_cnt - pe0, 1);
    check_output("parity_bad_frame_error", fe_cnt - fe0, 0);
    check_output("parity_bad_valid", {31'd0, rx_if.rx_valid}, 32'd0);
    wait_cycles(20);
`else
    pe0 = pe_cnt;
    check_output("no_parity_pulses", pe0, 0);
`endif

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
